rp_math_seq: RTL and testbench

//  Parametrised arithmetic engine for the math reconfigurable partition.

---
 rtl/rp_math_seq.sv | 128 ++++++++++++
 tb/tb_rp_math_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rp_math_seq.sv
// Arithmetic engine for the math RP: add/sub in one cycle, mul/mac via an
// iterative LSB-first shift-add multiplier, with valid/ready on both sides.
module rp_math_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] ain,
    input  logic [DATA_W-1:0] bin,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              acc_clr,
    output logic [DATA_W-1:0] result,
    output logic              flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] acc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    state_t state, state_nxt;

    logic [2*DATA_W-1:0] a_sh;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_nxt;
    logic [DATA_W-1:0]   b_sh;
    logic [CNT_W-1:0]    cnt;
    logic                mac_q;
    logic                mul_last;
    logic [DATA_W:0]     add_full;
    logic [DATA_W:0]     sub_full;
    logic [DATA_W:0]     mac_full;
    logic [DATA_W-1:0]   acc_base;

    assign in_ready = (state == S_IDLE);
    assign mul_last = (state == S_MUL) && (cnt == LAST);

    always_comb begin
        add_full = {1'b0, ain} + {1'b0, bin};
        // Top bit of the extended difference is the borrow (ain < bin).
        sub_full = {1'b0, ain} - {1'b0, bin};
        prod_nxt = prod + (b_sh[0] ? a_sh : '0);
        // A clear coinciding with mac completion accumulates onto zero.
        acc_base = acc_clr ? '0 : acc;
        mac_full = {1'b0, acc_base} + {1'b0, prod_nxt[DATA_W-1:0]};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = mode[1] ? S_MUL : S_DONE;
            S_MUL:   if (cnt == LAST) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            prod      <= '0;
            cnt       <= '0;
            mac_q     <= 1'b0;
            result    <= '0;
            flag      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= {{DATA_W{1'b0}}, ain};
                        b_sh  <= bin;
                        mac_q <= (mode == 2'b11);
                        cnt   <= '0;
                        prod  <= '0;
                        if (!mode[1]) begin
                            result    <= mode[0] ? sub_full[DATA_W-1:0] : add_full[DATA_W-1:0];
                            flag      <= mode[0] ? sub_full[DATA_W] : add_full[DATA_W];
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    prod <= prod_nxt;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (mul_last) begin
                        out_valid <= 1'b1;
                        if (mac_q) begin
                            result <= mac_full[DATA_W-1:0];
                            flag   <= mac_full[DATA_W] | (|prod_nxt[2*DATA_W-1:DATA_W]);
                        end else begin
                            result <= prod_nxt[DATA_W-1:0];
                            flag   <= |prod_nxt[2*DATA_W-1:DATA_W];
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)              acc <= '0;
        else if (mul_last && mac_q) acc <= mac_full[DATA_W-1:0];
        else if (acc_clr)          acc <= '0;
    end

endmodule

// File: tb/tb_rp_math_seq.sv
// Directed bench for rp_math_seq: vector table for add/sub/mul plus
// hand-written mac, backpressure and mid-operation reset sequences.
module tb_rp_math_seq;

    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic [DW-1:0] ain, bin;
    logic [1:0]    mode;
    logic          in_valid, in_ready, acc_clr, flag, out_valid, out_ready;
    logic [DW-1:0] result, acc;

    int n_checks = 0;
    int n_fail   = 0;

    rp_math_seq #(.DATA_W(DW), .CNT_W(6)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ain(ain), .bin(bin), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .acc_clr(acc_clr),
        .result(result), .flag(flag), .out_valid(out_valid),
        .out_ready(out_ready), .acc(acc)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]    m;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] r;
        logic          f;
    } vec_t;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Runs one operation, optionally pulsing acc_clr on the completion edge.
    task automatic do_op(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input bit clr_at_done, output logic [DW-1:0] r, output logic f,
                         output int lat);
        @(negedge Clk);
        in_valid = 1'b1; ain = a; bin = b; mode = m;
        @(posedge Clk);
        lat = 1;
        @(negedge Clk);
        in_valid = 1'b0; ain = $urandom; bin = $urandom; mode = 2'($urandom);
        while (!out_valid && lat < 100) begin
            acc_clr = clr_at_done && (lat == DW);
            @(posedge Clk);
            lat++;
            @(negedge Clk);
            acc_clr = 1'b0;
        end
        r = result;
        f = flag;
        out_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        out_ready = 1'b0;
        check("in_ready_after_handshake", 64'(in_ready), 64'd1);
    endtask

    vec_t          vecs[11];
    logic [DW-1:0] r;
    logic          f;
    int            lat;
    bit            stable;

    initial begin
        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1};
        vecs[1]  = '{2'b00, 32'h1,         32'h1,         32'h2,         1'b0};
        vecs[2]  = '{2'b00, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
        vecs[3]  = '{2'b01, 32'h3,         32'h5,         32'hFFFF_FFFE, 1'b1};
        vecs[4]  = '{2'b01, 32'h5,         32'h3,         32'h2,         1'b0};
        vecs[5]  = '{2'b01, 32'h0,         32'h0,         32'h0,         1'b0};
        vecs[6]  = '{2'b10, 32'h0001_0000, 32'h0001_0000, 32'h0,         1'b1};
        vecs[7]  = '{2'b10, 32'h1234,      32'h10,        32'h12340,     1'b0};
        vecs[8]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b1};
        vecs[9]  = '{2'b10, 32'h0,         32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[10] = '{2'b10, 32'hFFFF,      32'hFFFF,      32'hFFFE_0001, 1'b0};

        Reset_n = 1'b0; ain = '0; bin = '0; mode = '0;
        in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
        #23;
        check("rst_result",    64'(result),    64'd0);
        check("rst_flag",      64'(flag),      64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_acc",       64'(acc),       64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].m, vecs[i].a, vecs[i].b, 1'b0, r, f, lat);
            check($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].r));
            check($sformatf("vec%0d_flag", i),   64'(f), 64'(vecs[i].f));
            check($sformatf("vec%0d_latency", i), 64'(lat), vecs[i].m[1] ? 64'd33 : 64'd1);
        end
        check("acc_untouched_by_mul", 64'(acc), 64'd0);

        // Accumulator sequence.
        @(negedge Clk); acc_clr = 1'b1;
        @(negedge Clk); acc_clr = 1'b0;
        check("acc_clr_idle", 64'(acc), 64'd0);
        do_op(2'b11, 32'd3, 32'd4, 1'b0, r, f, lat);
        check("mac1_result", 64'(r), 64'd12);
        check("mac1_latency", 64'(lat), 64'd33);
        do_op(2'b11, 32'd5, 32'd6, 1'b0, r, f, lat);
        check("mac2_result", 64'(r), 64'd42);
        check("mac2_flag", 64'(f), 64'd0);
        check("mac2_acc", 64'(acc), 64'd42);
        @(negedge Clk); acc_clr = 1'b1;
        @(negedge Clk); acc_clr = 1'b0;
        check("acc_clr_alone", 64'(acc), 64'd0);
        check("acc_clr_keeps_result", 64'(result), 64'd42);
        do_op(2'b11, 32'd7, 32'd1, 1'b0, r, f, lat);
        check("mac3_acc", 64'(acc), 64'd7);
        do_op(2'b11, 32'd2, 32'd2, 1'b1, r, f, lat);
        check("mac_clr_done_result", 64'(r), 64'd4);
        check("mac_clr_done_acc", 64'(acc), 64'd4);
        do_op(2'b11, 32'hFFFF_FFFF, 32'd1, 1'b0, r, f, lat);
        check("mac_carry_result", 64'(r), 64'd3);
        check("mac_carry_flag", 64'(f), 64'd1);
        check("mac_carry_acc", 64'(acc), 64'd3);

        // Backpressure: result held, new input ignored while DONE.
        @(negedge Clk);
        in_valid = 1'b1; ain = 32'd10; bin = 32'd20; mode = 2'b00;
        @(posedge Clk);
        @(negedge Clk);
        ain = 32'd100; bin = 32'd200; mode = 2'b01;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (result !== 32'd30 || out_valid !== 1'b1 || in_ready !== 1'b0 || flag !== 1'b0)
                stable = 1'b0;
            @(negedge Clk);
        end
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_result", 64'(result), 64'd30);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk);
        out_ready = 1'b0;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of a multiply.
        @(negedge Clk);
        in_valid = 1'b1; ain = 32'hFFFF; bin = 32'hFFFF; mode = 2'b11;
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (10) @(negedge Clk);
        check("pre_rst_in_ready", 64'(in_ready), 64'd0);
        Reset_n = 1'b0;
        #1;
        check("midrst_result",    64'(result),    64'd0);
        check("midrst_flag",      64'(flag),      64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_acc",       64'(acc),       64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (40) @(negedge Clk);
        check("post_rst_no_output", 64'(out_valid), 64'd0);
        do_op(2'b00, 32'd1, 32'd1, 1'b0, r, f, lat);
        check("post_rst_add", 64'(r), 64'd2);
        check("post_rst_add_latency", 64'(lat), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
